// File: rtl/dqpath_sdr_16.sv
// SDR SDRAM 16-bit DQ datapath: 32-bit write words split into two beats, two read beats assembled into one word.
// Optional macro SDR_16_DQ_IOREG_EN adds an input flop on dq_i, pushing read capture and strobe one clock later.
module dqpath_sdr_16 #(
    parameter int CL = 2
) (
    input  logic        sdram_clk,
    input  logic        sdram_rst,
    input  logic        wr_en_i,
    input  logic        count0,
    input  logic [31:0] wr_data_i,
    input  logic        cmd_read,
    input  logic [15:0] dq_i,
    output logic [15:0] dq_o,
    output logic        dq_oe_o,
    output logic [31:0] rd_data_o,
    output logic        rd_we_o,
    input  logic        rd_full_i,
    output logic        ovf_o,
    output logic        err_o
);

    logic [15:0] dq_s;

`ifdef SDR_16_DQ_IOREG_EN
    localparam int LAT = CL + 1;
    logic [15:0] dq_q_r;

    // Input register on the DQ pins
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) dq_q_r <= 16'h0000;
        else           dq_q_r <= dq_i;
    end
    assign dq_s = dq_q_r;
`else
    localparam int LAT = CL;
    assign dq_s = dq_i;
`endif

    // Stage k is set during cycle T+k for a read accepted in cycle T; the command cycle itself is stage 0.
    logic [LAT+1:1] dl_r;
    logic           acc_s;
    logic [15:0]    dq_r;
    logic           dq_oe_r;
    logic [15:0]    beat1_r;
    logic [31:0]    rd_data_r;
    logic           pend_r;
    logic           ovf_r;
    logic           err_r;

    // A read directly following an accepted read would collide on the bus and is dropped
    assign acc_s = cmd_read & ~dl_r[1];

    // Write path: select the half-word for this beat and delay the enable to match
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            dq_r    <= 16'h0000;
            dq_oe_r <= 1'b0;
        end else begin
            dq_oe_r <= wr_en_i;
            if (wr_en_i) begin
                dq_r <= count0 ? wr_data_i[15:0] : wr_data_i[31:16];
            end else begin
                dq_r <= dq_r;
            end
        end
    end

    // Read path: latency tracking, beat capture and word assembly
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            dl_r      <= '0;
            beat1_r   <= 16'h0000;
            rd_data_r <= 32'h0000_0000;
            pend_r    <= 1'b0;
        end else begin
            dl_r   <= {dl_r[LAT:1], acc_s};
            pend_r <= dl_r[LAT+1];
            if (dl_r[LAT]) beat1_r <= dq_s;
            else           beat1_r <= beat1_r;
            if (dl_r[LAT+1]) rd_data_r <= {beat1_r, dq_s};
            else             rd_data_r <= rd_data_r;
        end
    end

    // Sticky error flags, cleared only by reset
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            ovf_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r | (pend_r & rd_full_i);
            err_r <= err_r | (cmd_read & dl_r[1]);
        end
    end

    // Strobe is gated by the FIFO full flag seen during the strobe cycle itself
    assign rd_we_o   = pend_r & ~rd_full_i;
    assign dq_o      = dq_r;
    assign dq_oe_o   = dq_oe_r;
    assign rd_data_o = rd_data_r;
    assign ovf_o     = ovf_r;
    assign err_o     = err_r;

endmodule

// File: tb/tb_dqpath_sdr_16.sv
// Self-checking bench for dqpath_sdr_16: directed scenarios plus randomized traffic against a cycle-indexed model.
module tb_dqpath_sdr_16;

    localparam int TB_CL = 2;
`ifdef SDR_16_DQ_IOREG_EN
    localparam int LAT = TB_CL + 1;
`else
    localparam int LAT = TB_CL;
`endif

    logic        sdram_clk = 1'b0;
    logic        sdram_rst = 1'b1;
    logic        wr_en_i = 1'b0;
    logic        count0 = 1'b0;
    logic [31:0] wr_data_i = 32'h0;
    logic        cmd_read = 1'b0;
    logic [15:0] dq_i = 16'h0;
    logic [15:0] dq_o;
    logic        dq_oe_o;
    logic [31:0] rd_data_o;
    logic        rd_we_o;
    logic        rd_full_i = 1'b0;
    logic        ovf_o;
    logic        err_o;

    dqpath_sdr_16 #(.CL(TB_CL)) dut (
        .sdram_clk(sdram_clk), .sdram_rst(sdram_rst), .wr_en_i(wr_en_i), .count0(count0),
        .wr_data_i(wr_data_i), .cmd_read(cmd_read), .dq_i(dq_i), .dq_o(dq_o), .dq_oe_o(dq_oe_o),
        .rd_data_o(rd_data_o), .rd_we_o(rd_we_o), .rd_full_i(rd_full_i), .ovf_o(ovf_o), .err_o(err_o)
    );

    always #5 sdram_clk = ~sdram_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: cycle counter, dq history by cycle, queue of expected strobe cycles
    int          cyc = 0;
    int          last_acc = -100;
    logic [15:0] hist [int];
    int          pq [$];
    logic        m_we, m_ovf, m_err, m_oe, n_ovf, n_err, n_oe;
    logic [15:0] m_dq, n_dq;
    logic [31:0] m_data;

    function automatic logic strobe_now();
        return (pq.size() > 0) && (pq[0] == cyc);
    endfunction

    // Apply inputs for the current cycle and compute what the design must show in it
    task automatic drive(input logic cmd, input logic [15:0] dq, input logic full,
                         input logic wr, input logic c0, input logic [31:0] wd);
        int t;
        cmd_read = cmd; dq_i = dq; rd_full_i = full; wr_en_i = wr; count0 = c0; wr_data_i = wd;
        hist[cyc] = dq;
        m_we = 1'b0;
        if (strobe_now()) begin
            t = pq.pop_front() - LAT - 2;
            m_data = {hist[t+LAT], hist[t+LAT+1]};
            m_we = !full;
            if (full) n_ovf = 1'b1;
        end
        if (cmd) begin
            if (last_acc == cyc - 1) n_err = 1'b1;
            else begin
                last_acc = cyc;
                pq.push_back(cyc + LAT + 2);
            end
        end
        n_oe = wr;
        if (wr) n_dq = c0 ? wd[15:0] : wd[31:16];
        #1;
    endtask

    task automatic tick();
        @(posedge sdram_clk);
        #1;
        cyc++;
        m_ovf = n_ovf; m_err = n_err; m_dq = n_dq; m_oe = n_oe; m_we = 1'b0;
    endtask

    task automatic do_reset();
        sdram_rst = 1'b1;
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        sdram_rst = 1'b0;
        pq.delete();
        last_acc = -100;
        {m_ovf, m_err, m_oe, n_ovf, n_err, n_oe, m_we} = 7'b0;
        m_dq = 16'h0; n_dq = 16'h0; m_data = 32'h0;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        n_tests += 6;
        if (dq_o !== 16'h0)      begin n_fail++; $display("FAIL reset_dq_o got %h exp 0000", dq_o); end
        if (dq_oe_o !== 1'b0)    begin n_fail++; $display("FAIL reset_dq_oe got %b exp 0", dq_oe_o); end
        if (rd_data_o !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data got %h exp 0", rd_data_o); end
        if (rd_we_o !== 1'b0)    begin n_fail++; $display("FAIL reset_rd_we got %b exp 0", rd_we_o); end
        if (ovf_o !== 1'b0)      begin n_fail++; $display("FAIL reset_ovf got %b exp 0", ovf_o); end
        if (err_o !== 1'b0)      begin n_fail++; $display("FAIL reset_err got %b exp 0", err_o); end
        tick();
    endtask

    task automatic test_write();
        logic [15:0] exp_dq [4];
        logic        exp_oe [4];
        exp_dq = '{16'h0000, 16'hA5A5, 16'h1234, 16'h1234};
        exp_oe = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 16'h0, 1'b0, (i < 2), (i == 1), 32'hA5A5_1234);
            n_tests += 2;
            if (dq_o !== exp_dq[i])  begin n_fail++; $display("FAIL write_dq c%0d got %h exp %h", i, dq_o, exp_dq[i]); end
            if (dq_oe_o !== exp_oe[i]) begin n_fail++; $display("FAIL write_oe c%0d got %b exp %b", i, dq_oe_o, exp_oe[i]); end
            tick();
        end
    endtask

    task automatic test_single_read();
        int t0 = cyc;
        logic [15:0] d;
        for (int i = 0; i < LAT + 5; i++) begin
            d = (i == LAT) ? 16'hBEEF : (i == LAT + 1) ? 16'hCAFE : 16'($urandom);
            drive(i == 0, d, 1'b0, 1'b0, 1'b0, 32'h0);
            n_tests++;
            if (rd_we_o !== (cyc == t0 + LAT + 2)) begin
                n_fail++; $display("FAIL single_rd_we c%0d got %b", i, rd_we_o);
            end
            if (cyc == t0 + LAT + 2) begin
                n_tests++;
                if (rd_data_o !== 32'hBEEF_CAFE) begin
                    n_fail++; $display("FAIL single_rd_data got %h exp beefcafe", rd_data_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int strobes = 0;
        for (int i = 0; i < 8 + LAT + 4; i++) begin
            drive((i < 8) && (i % 2 == 0), 16'($urandom), 1'b0, 1'($urandom), 1'($urandom), $urandom);
            n_tests++;
            if (rd_we_o !== m_we) begin n_fail++; $display("FAIL b2b_rd_we c%0d got %b exp %b", i, rd_we_o, m_we); end
            if (m_we) begin
                strobes++;
                n_tests++;
                if (rd_data_o !== m_data) begin n_fail++; $display("FAIL b2b_rd_data got %h exp %h", rd_data_o, m_data); end
            end
            tick();
        end
        n_tests++;
        if (strobes != 4) begin n_fail++; $display("FAIL b2b_count got %0d exp 4", strobes); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 2 * (LAT + 4); i++) begin
            drive((i == 0) || (i == LAT + 4), 16'($urandom), strobe_now() && (i < LAT + 4),
                  1'b0, 1'b0, 32'h0);
            n_tests += 2;
            if (rd_we_o !== m_we) begin n_fail++; $display("FAIL ovf_rd_we c%0d got %b exp %b", i, rd_we_o, m_we); end
            if (ovf_o !== m_ovf)  begin n_fail++; $display("FAIL ovf_flag c%0d got %b exp %b", i, ovf_o, m_ovf); end
            if (m_we) begin
                n_tests++;
                if (rd_data_o !== m_data) begin n_fail++; $display("FAIL ovf_rd_data got %h exp %h", rd_data_o, m_data); end
            end
            tick();
        end
        n_tests++;
        if (ovf_o !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b exp 1", ovf_o); end
    endtask

    task automatic test_adjacent_cmd();
        int strobes = 0;
        do_reset();
        for (int i = 0; i < LAT + 6; i++) begin
            drive(i < 2, 16'($urandom), 1'b0, 1'b0, 1'b0, 32'h0);
            if (rd_we_o === 1'b1) strobes++;
            if (m_we) begin
                n_tests++;
                if (rd_data_o !== m_data) begin n_fail++; $display("FAIL adj_rd_data got %h exp %h", rd_data_o, m_data); end
            end
            tick();
        end
        n_tests += 2;
        if (strobes != 1)   begin n_fail++; $display("FAIL adj_count got %0d exp 1", strobes); end
        if (err_o !== 1'b1) begin n_fail++; $display("FAIL adj_err got %b exp 1", err_o); end
    endtask

    task automatic test_reset_midread();
        drive(1'b1, 16'($urandom), 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF);
        tick();
        do_reset();
        for (int i = 0; i < LAT + 5; i++) begin
            drive(1'b0, 16'($urandom), 1'b0, 1'b0, 1'b0, 32'h0);
            n_tests++;
            if (rd_we_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd_we c%0d got %b exp 0", i, rd_we_o); end
            if (i == 0) begin
                n_tests++;
                if ({dq_o, dq_oe_o, rd_data_o, ovf_o, err_o} !== 51'h0) begin
                    n_fail++; $display("FAIL rstmid_outputs dq=%h oe=%b rd=%h ovf=%b err=%b exp all 0",
                                       dq_o, dq_oe_o, rd_data_o, ovf_o, err_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 3, 16'($urandom), $urandom_range(0, 9) < 2,
                  1'($urandom), 1'($urandom), $urandom);
            n_tests += 5;
            if (rd_we_o !== m_we)  begin n_fail++; $display("FAIL rnd_rd_we c%0d got %b exp %b", cyc, rd_we_o, m_we); end
            if (ovf_o !== m_ovf)   begin n_fail++; $display("FAIL rnd_ovf c%0d got %b exp %b", cyc, ovf_o, m_ovf); end
            if (err_o !== m_err)   begin n_fail++; $display("FAIL rnd_err c%0d got %b exp %b", cyc, err_o, m_err); end
            if (dq_o !== m_dq)     begin n_fail++; $display("FAIL rnd_dq c%0d got %h exp %h", cyc, dq_o, m_dq); end
            if (dq_oe_o !== m_oe)  begin n_fail++; $display("FAIL rnd_oe c%0d got %b exp %b", cyc, dq_oe_o, m_oe); end
            if (m_we) begin
                n_tests++;
                if (rd_data_o !== m_data) begin n_fail++; $display("FAIL rnd_rd_data c%0d got %h exp %h", cyc, rd_data_o, m_data); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_single_read();
        test_back_to_back();
        test_overflow();
        test_adjacent_cmd();
        test_reset_midread();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
